// File: rtl/dequant_int8_8ch.sv
// -----------------------------------------------------------------------------
// dequant_int8_8ch
//
// Purpose:
//   Inverse of the 8-channel int8 requantizer. Each beat carries 8 packed
//   uint8 activations. Every channel has the zero point subtracted, is scaled
//   by an unsigned multiplier, and is then rounded-arithmetic-right-shifted.
//   The result is sign-extended into the int32 accumulator domain so it can
//   be merged with conv accumulators on residual-add and concat paths.
//
//   Three-stage pipeline with a single global stall:
//     S1: d = x - zero_point          (9-bit signed, -255..255)
//     S2: p = d * mult                (25-bit signed)
//     S3: r = round_shift(p, shift)   (26-bit signed, sign-extended to OUT_W)
//   The per-beat configuration (mult, shift, zero_point) is captured with the
//   accepted beat and travels down the pipeline alongside it.
//
// Ports:
//   sclk                      clock
//   s_rst                     synchronous active-high reset
//   in_data[63:0]             8 x uint8 activations, ch0 = [7:0]
//   in_vld / in_rdy           input handshake
//   in_last                   last beat of tile, carried with the data
//   mult[14:0]                unsigned scale, sampled per accepted beat
//   shift[4:0]                right-shift amount (25..31 act as 24)
//   zero_point[7:0]           unsigned zero point, sampled per accepted beat
//   ch0_data_out..ch7_data_out  signed dequantized results
//   out_vld / out_rdy         output handshake
//   out_last                  in_last of the beat currently presented
// -----------------------------------------------------------------------------
module dequant_int8_8ch #(
    parameter int CH_NUM = 8,
    parameter int OUT_W  = 32
) (
    input  logic                  sclk,
    input  logic                  s_rst,
    input  logic [8*CH_NUM-1:0]   in_data,
    input  logic                  in_vld,
    input  logic                  in_last,
    output logic                  in_rdy,
    input  logic [14:0]           mult,
    input  logic [4:0]            shift,
    input  logic [7:0]            zero_point,
    output logic [OUT_W-1:0]      ch0_data_out,
    output logic [OUT_W-1:0]      ch1_data_out,
    output logic [OUT_W-1:0]      ch2_data_out,
    output logic [OUT_W-1:0]      ch3_data_out,
    output logic [OUT_W-1:0]      ch4_data_out,
    output logic [OUT_W-1:0]      ch5_data_out,
    output logic [OUT_W-1:0]      ch6_data_out,
    output logic [OUT_W-1:0]      ch7_data_out,
    output logic                  out_vld,
    output logic                  out_last,
    input  logic                  out_rdy
);

    localparam int D_W = 9;   // zero-point-corrected value
    localparam int P_W = 25;  // scaled product
    localparam int R_W = 26;  // rounding headroom: |p| + 2^23 still fits
    localparam logic [4:0] SHIFT_MAX = 5'd24;

    // -------------------------------------------------------------------------
    // Datapath helpers
    // -------------------------------------------------------------------------

    // x - zero_point, both treated as unsigned bytes
    function automatic logic signed [D_W-1:0] sub_zp(
        input logic [7:0] x,
        input logic [7:0] zp
    );
        sub_zp = $signed({1'b0, x}) - $signed({1'b0, zp});
    endfunction

    // d * mult on a full 25-bit signed product (mult is zero-extended)
    function automatic logic signed [P_W-1:0] scale(
        input logic signed [D_W-1:0] d,
        input logic        [14:0]    m
    );
        logic signed [P_W-1:0] d_ext;
        logic signed [P_W-1:0] m_ext;
        d_ext = {{(P_W-D_W){d[D_W-1]}}, d};
        m_ext = {{(P_W-15){1'b0}}, m};
        scale = d_ext * m_ext;
    endfunction

    // Rounding arithmetic right shift; adding half an LSB before the
    // floor-shift rounds ties toward +inf for both signs.
    function automatic logic signed [R_W-1:0] round_shift(
        input logic signed [P_W-1:0] p,
        input logic        [4:0]     sh
    );
        logic        [4:0]     s;
        logic signed [R_W-1:0] p_ext;
        logic signed [R_W-1:0] bias;
        s     = (sh > SHIFT_MAX) ? SHIFT_MAX : sh;
        p_ext = {p[P_W-1], p};
        bias  = 26'sd0;
        if (s == 5'd0) begin
            round_shift = p_ext;
        end else begin
            bias        = 26'sd1 <<< (s - 5'd1);
            round_shift = (p_ext + bias) >>> s;
        end
    endfunction

    // -------------------------------------------------------------------------
    // Pipeline state
    // -------------------------------------------------------------------------
    logic                  adv_s;

    logic                  s1_vld_q,   s1_vld_d;
    logic                  s1_last_q,  s1_last_d;
    logic signed [D_W-1:0] s1_diff_q  [CH_NUM];
    logic signed [D_W-1:0] s1_diff_d  [CH_NUM];
    logic [14:0]           s1_mult_q,  s1_mult_d;
    logic [4:0]            s1_shift_q, s1_shift_d;

    logic                  s2_vld_q,   s2_vld_d;
    logic                  s2_last_q,  s2_last_d;
    logic signed [P_W-1:0] s2_prod_q  [CH_NUM];
    logic signed [P_W-1:0] s2_prod_d  [CH_NUM];
    logic [4:0]            s2_shift_q, s2_shift_d;

    logic                  out_vld_q,  out_vld_d;
    logic                  out_last_q, out_last_d;
    logic [OUT_W-1:0]      out_data_q [CH_NUM];
    logic [OUT_W-1:0]      out_data_d [CH_NUM];

    logic signed [R_W-1:0] round_s    [CH_NUM];

    // Single global stall: the whole pipe moves whenever the output slot
    // is empty or being drained this cycle. Bubbles are kept, not collapsed.
    assign adv_s  = ~out_vld_q | out_rdy;
    assign in_rdy = adv_s;

    // Next-state for every stage: load from the previous stage on advance,
    // otherwise hold data, valid bits and carried config.
    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_last_d  = s1_last_q;
        s1_mult_d  = s1_mult_q;
        s1_shift_d = s1_shift_q;
        s2_vld_d   = s2_vld_q;
        s2_last_d  = s2_last_q;
        s2_shift_d = s2_shift_q;
        out_vld_d  = out_vld_q;
        out_last_d = out_last_q;
        for (int i = 0; i < CH_NUM; i++) begin
            s1_diff_d[i]  = s1_diff_q[i];
            s2_prod_d[i]  = s2_prod_q[i];
            out_data_d[i] = out_data_q[i];
            round_s[i]    = round_shift(s2_prod_q[i], s2_shift_q);
        end

        if (adv_s) begin
            // S1: capture beat, config and zero-point correction
            s1_vld_d   = in_vld;
            s1_last_d  = in_last;
            s1_mult_d  = mult;
            s1_shift_d = shift;
            // S2: scale
            s2_vld_d   = s1_vld_q;
            s2_last_d  = s1_last_q;
            s2_shift_d = s1_shift_q;
            // S3: round/shift and widen into the accumulator domain
            out_vld_d  = s2_vld_q;
            out_last_d = s2_last_q;
            for (int i = 0; i < CH_NUM; i++) begin
                s1_diff_d[i]  = sub_zp(in_data[8*i +: 8], zero_point);
                s2_prod_d[i]  = scale(s1_diff_q[i], s1_mult_q);
                out_data_d[i] = {{(OUT_W-R_W){round_s[i][R_W-1]}}, round_s[i]};
            end
        end else begin
            s1_vld_d  = s1_vld_q;
            s2_vld_d  = s2_vld_q;
            out_vld_d = out_vld_q;
        end
    end

    // Pipeline registers; reset drops every beat in flight and zeroes outputs.
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            s1_vld_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_mult_q  <= 15'd0;
            s1_shift_q <= 5'd0;
            s2_vld_q   <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_shift_q <= 5'd0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            for (int i = 0; i < CH_NUM; i++) begin
                s1_diff_q[i]  <= 9'sd0;
                s2_prod_q[i]  <= 25'sd0;
                out_data_q[i] <= {OUT_W{1'b0}};
            end
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_last_q  <= s1_last_d;
            s1_mult_q  <= s1_mult_d;
            s1_shift_q <= s1_shift_d;
            s2_vld_q   <= s2_vld_d;
            s2_last_q  <= s2_last_d;
            s2_shift_q <= s2_shift_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
            for (int i = 0; i < CH_NUM; i++) begin
                s1_diff_q[i]  <= s1_diff_d[i];
                s2_prod_q[i]  <= s2_prod_d[i];
                out_data_q[i] <= out_data_d[i];
            end
        end
    end

    assign out_vld      = out_vld_q;
    assign out_last     = out_last_q;
    assign ch0_data_out = out_data_q[0];
    assign ch1_data_out = out_data_q[1];
    assign ch2_data_out = out_data_q[2];
    assign ch3_data_out = out_data_q[3];
    assign ch4_data_out = out_data_q[4];
    assign ch5_data_out = out_data_q[5];
    assign ch6_data_out = out_data_q[6];
    assign ch7_data_out = out_data_q[7];

endmodule
